// File: rtl/stopwatch_disp_pkg.sv
// Shared definitions for the stopwatch display driver: digit count, 7-segment
// glyphs (active-low, bit order gfedcba), lamp bit positions, the digit-slot
// enum and the binary-to-BCD helper used when decoding the snapshot.
package stopwatch_disp_pkg;

   localparam int unsigned NUM_DIGITS = 6;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

   localparam int unsigned LIGHT_RED = 2;
   localparam int unsigned LIGHT_YEL = 1;
   localparam int unsigned LIGHT_GRN = 0;

   // Scan slot; value equals the an[] bit that is driven low.
   typedef enum logic [2:0] {
      DIG_HOUR_T = 3'd0,
      DIG_HOUR_U = 3'd1,
      DIG_MIN_T  = 3'd2,
      DIG_MIN_U  = 3'd3,
      DIG_SEC_T  = 3'd4,
      DIG_SEC_U  = 3'd5
   } digit_e;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t tens;
      bcd_t units;
   } bcd_pair_t;

   typedef struct packed {
      logic [3:0] hour;
      logic [5:0] min;
      logic [5:0] sec;
   } snap_t;

   // Repeated subtraction of ten; six steps cover the full 0..63 input range.
   function automatic bcd_pair_t to_bcd(input logic [5:0] v);
      bcd_pair_t  r;
      logic [5:0] rem;
      r.tens = '0;
      rem    = v;
      for (int unsigned i = 0; i < 6; i++) begin
         if (rem >= 6'd10) begin
            rem    = rem - 6'd10;
            r.tens = r.tens + 4'd1;
         end
      end
      r.units = rem[3:0];
      return r;
   endfunction

endpackage

// File: rtl/stopwatch_display_driver_if.sv
// Signal bundle between the stopwatch/traffic-light logic and the display
// driver.
//   enable, hour, min, sec, light : time and lamp code into the driver
//   an, seg                       : active-low digit enables and segments
//   led_r, led_y, led_g           : lamp drives
//   light_fault                   : registered light code not one-hot
//   frame_done                    : one-cycle pulse after a snapshot load
// master drives the inputs and observes the outputs; slave is the driver.
interface stopwatch_display_driver_if;
   import stopwatch_disp_pkg::*;

   logic                  enable;
   logic [3:0]            hour;
   logic [5:0]            min;
   logic [5:0]            sec;
   logic [2:0]            light;
   logic [NUM_DIGITS-1:0] an;
   logic [6:0]            seg;
   logic                  led_r;
   logic                  led_y;
   logic                  led_g;
   logic                  light_fault;
   logic                  frame_done;

   modport master (
      output enable, hour, min, sec, light,
      input  an, seg, led_r, led_y, led_g, light_fault, frame_done
   );

   modport slave (
      input  enable, hour, min, sec, light,
      output an, seg, led_r, led_y, led_g, light_fault, frame_done
   );

endinterface

// File: rtl/stopwatch_display_driver_seg7_decode.sv
// Combinational 7-segment decoder.
//   bcd  : digit value 0..9 (10..15 render blank)
//   dash : forces the dash glyph, overriding bcd
//   seg  : active-low segments, gfedcba
module seg7_decode
   import stopwatch_disp_pkg::*;
(
   input  bcd_t       bcd,
   input  logic       dash,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (dash) begin
         seg = SEG_DASH;
      end else begin
         case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/stopwatch_display_driver.sv
// Six-digit multiplexed HH:MM:SS display driver with traffic-light lamp drive.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : stopwatch_display_driver_if.slave (time/light in, an/seg/lamps out)
// Each digit is lit for SCAN_DIV cycles. Time is sampled into a snapshot only
// at the end of a frame so a frame never mixes old and new values.
module stopwatch_display_driver
   import stopwatch_disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 4
) (
   input logic                       clk,
   input logic                       rst,
   stopwatch_display_driver_if.slave bus
);

   localparam logic [15:0]           DIV_LAST = 16'(SCAN_DIV - 1);
   localparam logic [NUM_DIGITS-1:0] AN_LSB   = NUM_DIGITS'(1);

   logic [15:0]           div_q,   div_d;
   digit_e                dig_q,   dig_d;
   snap_t                 snap_q,  snap_d;
   logic [NUM_DIGITS-1:0] an_q,    an_d;
   logic [6:0]            seg_q,   seg_d;
   logic                  led_r_q, led_r_d;
   logic                  led_y_q, led_y_d;
   logic                  led_g_q, led_g_d;
   logic                  fault_q, fault_d;
   logic                  frame_done_q, frame_done_d;

   bcd_pair_t hour_bcd, min_bcd, sec_bcd;
   logic      min_dash, sec_dash;
   bcd_t      dec_bcd;
   logic      dec_dash;
   logic [6:0] dec_seg;
   logic      tc;
   logic      light_one_hot;

   // Digit source: the snapshot only, never the live inputs.
   always_comb begin
      hour_bcd = to_bcd({2'b00, snap_q.hour});
      min_bcd  = to_bcd(snap_q.min);
      sec_bcd  = to_bcd(snap_q.sec);
      min_dash = (snap_q.min > 6'd59);
      sec_dash = (snap_q.sec > 6'd59);
      dec_bcd  = '0;
      dec_dash = 1'b0;
      case (dig_q)
         DIG_HOUR_T: dec_bcd = hour_bcd.tens;
         DIG_HOUR_U: dec_bcd = hour_bcd.units;
         DIG_MIN_T:  begin dec_bcd = min_bcd.tens;  dec_dash = min_dash; end
         DIG_MIN_U:  begin dec_bcd = min_bcd.units; dec_dash = min_dash; end
         DIG_SEC_T:  begin dec_bcd = sec_bcd.tens;  dec_dash = sec_dash; end
         DIG_SEC_U:  begin dec_bcd = sec_bcd.units; dec_dash = sec_dash; end
         default:    begin dec_bcd = '0;            dec_dash = 1'b0;     end
      endcase
   end

   seg7_decode u_decode (
      .bcd  (dec_bcd),
      .dash (dec_dash),
      .seg  (dec_seg)
   );

   always_comb begin
      tc            = (div_q == DIV_LAST);
      light_one_hot = $onehot(bus.light);

      div_d        = div_q;
      dig_d        = dig_q;
      snap_d       = snap_q;
      an_d         = AN_OFF;
      seg_d        = SEG_BLANK;
      frame_done_d = 1'b0;

      if (bus.enable) begin
         // an/seg follow the current slot, so they trail a slot change by one clock.
         an_d  = ~(AN_LSB << dig_q);
         seg_d = dec_seg;
         if (tc) begin
            div_d = '0;
            if (dig_q == DIG_SEC_U) begin
               dig_d        = DIG_HOUR_T;
               snap_d.hour  = bus.hour;
               snap_d.min   = bus.min;
               snap_d.sec   = bus.sec;
               frame_done_d = 1'b1;
            end else begin
               dig_d = digit_e'(dig_q + 3'd1);
            end
         end else begin
            div_d = div_q + 16'd1;
         end
      end

      // Lamp outputs are the registered form of the light code; holding the
      // decoded result (rather than the raw code) lets reset read as no fault.
      led_r_d = light_one_hot & bus.light[LIGHT_RED];
      led_y_d = light_one_hot & bus.light[LIGHT_YEL];
      led_g_d = light_one_hot & bus.light[LIGHT_GRN];
      fault_d = ~light_one_hot;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q        <= '0;
         dig_q        <= DIG_HOUR_T;
         snap_q       <= '0;
         an_q         <= AN_OFF;
         seg_q        <= SEG_BLANK;
         led_r_q      <= 1'b0;
         led_y_q      <= 1'b0;
         led_g_q      <= 1'b0;
         fault_q      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         div_q        <= div_d;
         dig_q        <= dig_d;
         snap_q       <= snap_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         led_r_q      <= led_r_d;
         led_y_q      <= led_y_d;
         led_g_q      <= led_g_d;
         fault_q      <= fault_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.an          = an_q;
   assign bus.seg         = seg_q;
   assign bus.led_r       = led_r_q;
   assign bus.led_y       = led_y_q;
   assign bus.led_g       = led_g_q;
   assign bus.light_fault = fault_q;
   assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_stopwatch_display_driver.sv
module tb_stopwatch_display_driver;

   typedef struct {
      logic [3:0]      hour;
      logic [5:0]      min;
      logic [5:0]      sec;
      logic [5:0][6:0] seg;
   } vec_t;

   typedef struct {
      logic [2:0] light;
      logic [3:0] exp_ryg_f;
   } lvec_t;

   // Glyphs 0..9 then dash at index 10.
   localparam logic [6:0] GL [11] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
      7'b0111111
   };
   localparam int DASH = 10;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   stopwatch_display_driver_if bus ();

   stopwatch_display_driver #(.SCAN_DIV(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] an_exp(input int d);
      logic [5:0] a;
      a    = 6'b111111;
      a[d] = 1'b0;
      return a;
   endfunction

   function automatic vec_t mk(input logic [3:0] h, input logic [5:0] m, input logic [5:0] s,
                               input int g0, input int g1, input int g2,
                               input int g3, input int g4, input int g5);
      vec_t v;
      v.hour   = h;
      v.min    = m;
      v.sec    = s;
      v.seg[0] = GL[g0];
      v.seg[1] = GL[g1];
      v.seg[2] = GL[g2];
      v.seg[3] = GL[g3];
      v.seg[4] = GL[g4];
      v.seg[5] = GL[g5];
      return v;
   endfunction

   // Advance on negedges until frame_done is seen; bounded.
   task automatic wait_frame(output int waited);
      waited = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         waited++;
         if (bus.frame_done === 1'b1) return;
      end
      chk("frame_done_timeout", 32'(waited), 32'hFFFF);
   endtask

   // Entered at the negedge where frame_done is high; leaves 22 cycles later.
   task automatic check_frame(input logic [5:0][6:0] exp, input logic tear, input logic [5:0] new_sec);
      @(negedge clk);
      chk("frame_done_width", 32'(bus.frame_done), 32'd0);
      @(negedge clk);
      for (int d = 0; d < 6; d++) begin
         if (d > 0) repeat (4) @(negedge clk);
         chk($sformatf("an_d%0d", d), 32'(bus.an), 32'(an_exp(d)));
         chk($sformatf("seg_d%0d", d), 32'(bus.seg), 32'(exp[d]));
         if (tear && d == 2) bus.sec = new_sec;
      end
   endtask

   vec_t  vecs [6];
   lvec_t lvecs [9];

   initial begin
      int         w;
      logic [3:0] prev_leds;

      vecs[0] = mk(4'd3,  6'd7,  6'd42, 0, 3, 0, 7, 4, 2);
      vecs[1] = mk(4'd15, 6'd60, 6'd63, 1, 5, DASH, DASH, DASH, DASH);
      vecs[2] = mk(4'd0,  6'd59, 6'd59, 0, 0, 5, 9, 5, 9);
      vecs[3] = mk(4'd12, 6'd0,  6'd9,  1, 2, 0, 0, 0, 9);
      vecs[4] = mk(4'd9,  6'd18, 6'd60, 0, 9, 1, 8, DASH, DASH);
      vecs[5] = mk(4'd7,  6'd36, 6'd51, 0, 7, 3, 6, 5, 1);

      lvecs[0] = '{3'b100, 4'b1000};
      lvecs[1] = '{3'b010, 4'b0100};
      lvecs[2] = '{3'b001, 4'b0010};
      lvecs[3] = '{3'b110, 4'b0001};
      lvecs[4] = '{3'b000, 4'b0001};
      lvecs[5] = '{3'b011, 4'b0001};
      lvecs[6] = '{3'b101, 4'b0001};
      lvecs[7] = '{3'b111, 4'b0001};
      lvecs[8] = '{3'b100, 4'b1000};

      // Reset state; live inputs already nonzero to prove they never reach seg.
      rst        = 1'b0;
      bus.enable = 1'b0;
      bus.hour   = 4'd3;
      bus.min    = 6'd7;
      bus.sec    = 6'd42;
      bus.light  = 3'b001;
      @(negedge clk);
      chk("rst_an", 32'(bus.an), 32'h3F);
      chk("rst_seg", 32'(bus.seg), 32'h7F);
      chk("rst_leds", 32'({bus.led_r, bus.led_y, bus.led_g, bus.light_fault}), 32'd0);
      chk("rst_frame_done", 32'(bus.frame_done), 32'd0);

      // First frame after release: 4 cycles per digit, 00:00:00 shown.
      rst        = 1'b1;
      bus.enable = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         chk($sformatf("scan_an_k%0d", k), 32'(bus.an), 32'(an_exp((k - 1) / 4)));
         chk($sformatf("scan_seg_k%0d", k), 32'(bus.seg), 32'(GL[0]));
         chk($sformatf("scan_fd_k%0d", k), 32'(bus.frame_done), (k == 24) ? 32'd1 : 32'd0);
      end

      // Table-driven snapshot/decode vectors.
      for (int i = 0; i < 6; i++) begin
         bus.hour = vecs[i].hour;
         bus.min  = vecs[i].min;
         bus.sec  = vecs[i].sec;
         wait_frame(w);
         chk($sformatf("frame_period_v%0d", i), 32'(w), (i == 0) ? 32'd24 : 32'd2);
         check_frame(vecs[i].seg, 1'b0, 6'd0);
      end

      // Tearing: sec 42 -> 43 during d2 must not show until the next frame.
      bus.hour = 4'd3;
      bus.min  = 6'd7;
      bus.sec  = 6'd42;
      wait_frame(w);
      chk("tear_period0", 32'(w), 32'd2);
      check_frame({GL[2], GL[4], GL[7], GL[0], GL[3], GL[0]}, 1'b1, 6'd43);
      wait_frame(w);
      chk("tear_period1", 32'(w), 32'd2);
      check_frame({GL[3], GL[4], GL[7], GL[0], GL[3], GL[0]}, 1'b0, 6'd0);

      // Enable low for 10 cycles during d3, then resume with remaining count.
      wait_frame(w);
      chk("en_period0", 32'(w), 32'd2);
      repeat (13) @(negedge clk);
      chk("en_pre_an", 32'(bus.an), 32'(an_exp(3)));
      bus.enable = 1'b0;
      @(negedge clk);
      chk("en_off_an_first", 32'(bus.an), 32'h3F);
      chk("en_off_seg_first", 32'(bus.seg), 32'h7F);
      repeat (9) @(negedge clk);
      chk("en_off_an_last", 32'(bus.an), 32'h3F);
      chk("en_off_seg_last", 32'(bus.seg), 32'h7F);
      chk("en_off_fd", 32'(bus.frame_done), 32'd0);
      bus.enable = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk($sformatf("en_resume_an%0d", j), 32'(bus.an), 32'(an_exp(3)));
         chk($sformatf("en_resume_seg%0d", j), 32'(bus.seg), 32'(GL[7]));
      end
      @(negedge clk);
      chk("en_next_an", 32'(bus.an), 32'(an_exp(4)));
      chk("en_next_seg", 32'(bus.seg), 32'(GL[4]));
      wait_frame(w);
      chk("en_period1", 32'(w), 32'd7);

      // Lamps: registered, one cycle after the code changes.
      prev_leds = 4'b0010;
      for (int i = 0; i < 9; i++) begin
         bus.light = lvecs[i].light;
         #1;
         chk($sformatf("light_hold_%0d", i),
             32'({bus.led_r, bus.led_y, bus.led_g, bus.light_fault}), 32'(prev_leds));
         @(negedge clk);
         chk($sformatf("light_%b", lvecs[i].light),
             32'({bus.led_r, bus.led_y, bus.led_g, bus.light_fault}), 32'(lvecs[i].exp_ryg_f));
         prev_leds = lvecs[i].exp_ryg_f;
      end

      // Mid-scan reset: immediate clear, then restart at d0 with zero snapshot.
      repeat (5) @(negedge clk);
      chk("mid_pre_led_r", 32'(bus.led_r), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_an", 32'(bus.an), 32'h3F);
      chk("mid_rst_seg", 32'(bus.seg), 32'h7F);
      chk("mid_rst_leds", 32'({bus.led_r, bus.led_y, bus.led_g, bus.light_fault}), 32'd0);
      chk("mid_rst_fd", 32'(bus.frame_done), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk($sformatf("mid_an_k%0d", k), 32'(bus.an), 32'(an_exp((k - 1) / 4)));
         chk($sformatf("mid_seg_k%0d", k), 32'(bus.seg), 32'(GL[0]));
      end
      wait_frame(w);
      chk("mid_period", 32'(w), 32'd19);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
